// File: rtl/sr_control_mc.sv
// sr_control_mc
// Multicycle control unit for the schoolRISCV core. It replaces the single-cycle
// combinational decoder when the core is built in multicycle mode. Each
// instruction is walked through fetch, decode, execute and memory states, with
// valid/ack handshakes towards instruction and data memory.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   imem_ack, dmem_ack   memory acks, honoured only while the matching req is high
//   cmdOp/cmdF3/cmdF7    opcode / funct3 / funct7 from the instruction register
//   aluZero/aluLt/aluLtu ALU flags used to resolve branches
//   imem_req, irWrite    fetch request and instruction register load strobe
//   dmem_req, dmem_we    data request and write enable
//   pcWrite, pcSrc       PC update and source (00 pc+4, 01 pc+immB/J, 10 (rs1+immI)&~1)
//   regWrite, aluSrc     register write enable; ALU operand B select (1 = immediate)
//   wdSrc                write-back select (00 ALU, 01 immU, 10 memory, 11 pc+4)
//   aluControl           ALU operation code
//   invalid_instr        sticky trap flag
//   retired              instructions completed since reset (wrapping)
//
// State   | meaning
// --------+---------------------------------------------------------------
// FETCH   | request the next instruction, load IR on imem_ack
// DECODE  | classify IR: invalid -> TRAP, LW/SW -> MEM, else -> EXEC
// EXEC    | one cycle driving the instruction's control outputs
// MEM     | data access for LW/SW, completes on dmem_ack
// TRAP    | invalid encoding or memory timeout; left only through rst

module sr_control_mc #(
    parameter int ALU_W       = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic [6:0]       cmdOp,
    input  logic [2:0]       cmdF3,
    input  logic [6:0]       cmdF7,
    input  logic             aluZero,
    input  logic             aluLt,
    input  logic             aluLtu,
    output logic             imem_req,
    output logic             irWrite,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             regWrite,
    output logic             aluSrc,
    output logic [1:0]       wdSrc,
    output logic [ALU_W-1:0] aluControl,
    output logic             invalid_instr,
    output logic [CNT_W-1:0] retired
);

    // ALU operation codes shared with the datapath
    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(9);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Wait counter compares against MEM_TIMEOUT-1: the request is held for
    // exactly MEM_TIMEOUT cycles, and an ack in the last one still completes.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU_R,
        CL_ALU_I,
        CL_LUI,
        CL_JAL,
        CL_JALR,
        CL_BRANCH,
        CL_LOAD,
        CL_STORE
    } instrClass_t;

    state_t            state;
    state_t            stateNext;
    logic [7:0]        waitCnt;
    logic              timeoutHit;
    logic [CNT_W-1:0]  retiredQ;
    logic              retire;

    instrClass_t       decClass;
    logic              decValid;
    logic [ALU_W-1:0]  decAlu;
    logic              brTaken;

    // funct3 -> ALU op for the base (funct7 = 0) encodings
    function automatic logic [ALU_W-1:0] f3Alu(input logic [2:0] f3);
        case (f3)
            3'b000:  f3Alu = ALU_ADD;
            3'b001:  f3Alu = ALU_SLL;
            3'b010:  f3Alu = ALU_SLT;
            3'b011:  f3Alu = ALU_SLTU;
            3'b100:  f3Alu = ALU_XOR;
            3'b101:  f3Alu = ALU_SRL;
            3'b110:  f3Alu = ALU_OR;
            default: f3Alu = ALU_AND;
        endcase
    endfunction

    // Instruction classification; IR is stable from DECODE until the next fetch
    always_comb begin
        decClass = CL_ALU_R;
        decValid = 1'b0;
        decAlu   = ALU_ADD;
        brTaken  = 1'b0;
        case (cmdOp)
            OP_R: begin
                decClass = CL_ALU_R;
                if (cmdF7 == F7_BASE) begin
                    decValid = 1'b1;
                    decAlu   = f3Alu(cmdF3);
                end else if (cmdF7 == F7_ALT) begin
                    if (cmdF3 == 3'b000) begin
                        decValid = 1'b1;
                        decAlu   = ALU_SUB;
                    end else if (cmdF3 == 3'b101) begin
                        decValid = 1'b1;
                        decAlu   = ALU_SRA;
                    end
                end
            end
            OP_I: begin
                decClass = CL_ALU_I;
                decAlu   = f3Alu(cmdF3);
                case (cmdF3)
                    // F7 carries immediate bits except for the shift forms
                    3'b001:  decValid = (cmdF7 == F7_BASE);
                    3'b101: begin
                        if (cmdF7 == F7_BASE) begin
                            decValid = 1'b1;
                        end else if (cmdF7 == F7_ALT) begin
                            decValid = 1'b1;
                            decAlu   = ALU_SRA;
                        end
                    end
                    default: decValid = 1'b1;
                endcase
            end
            OP_LUI: begin
                decClass = CL_LUI;
                decValid = 1'b1;
            end
            OP_JAL: begin
                decClass = CL_JAL;
                decValid = 1'b1;
            end
            OP_JALR: begin
                decClass = CL_JALR;
                decValid = (cmdF3 == 3'b000);
            end
            OP_BRANCH: begin
                decClass = CL_BRANCH;
                decValid = 1'b1;
                case (cmdF3)
                    3'b000:  brTaken = aluZero;
                    3'b001:  brTaken = !aluZero;
                    3'b100:  brTaken = aluLt;
                    3'b101:  brTaken = !aluLt;
                    3'b110:  brTaken = aluLtu;
                    3'b111:  brTaken = !aluLtu;
                    default: decValid = 1'b0;
                endcase
            end
            OP_LOAD: begin
                decClass = CL_LOAD;
                decValid = (cmdF3 == 3'b010);
            end
            OP_STORE: begin
                decClass = CL_STORE;
                decValid = (cmdF3 == 3'b010);
            end
            default: decValid = 1'b0;
        endcase
    end

    assign timeoutHit = (waitCnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // Cleared on every state change, so each entry to FETCH or MEM starts at 0
    always_ff @(posedge clk) begin
        if (rst || (stateNext != state)) begin
            waitCnt <= 8'd0;
        end else if ((state == S_FETCH) || (state == S_MEM)) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retiredQ <= '0;
        end else if (retire) begin
            retiredQ <= retiredQ + CNT_W'(1);
        end
    end

    // The counter register clears on the first reset edge; masking makes the
    // output read 0 for the whole time rst is high.
    assign retired = rst ? '0 : retiredQ;

    // Next state and outputs. Everything is skipped under rst so all outputs
    // are 0 and any outstanding request is dropped immediately.
    always_comb begin
        stateNext     = state;
        retire        = 1'b0;
        imem_req      = 1'b0;
        irWrite       = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        pcWrite       = 1'b0;
        pcSrc         = 2'b00;
        regWrite      = 1'b0;
        aluSrc        = 1'b0;
        wdSrc         = 2'b00;
        aluControl    = ALU_ADD;
        invalid_instr = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        irWrite   = 1'b1;
                        stateNext = S_DECODE;
                    end else if (timeoutHit) begin
                        stateNext = S_TRAP;
                    end
                end
                S_DECODE: begin
                    if (!decValid) begin
                        stateNext = S_TRAP;
                    end else if ((decClass == CL_LOAD) || (decClass == CL_STORE)) begin
                        stateNext = S_MEM;
                    end else begin
                        stateNext = S_EXEC;
                    end
                end
                S_EXEC: begin
                    pcWrite   = 1'b1;
                    retire    = 1'b1;
                    stateNext = S_FETCH;
                    case (decClass)
                        CL_ALU_R: begin
                            regWrite   = 1'b1;
                            aluControl = decAlu;
                        end
                        CL_ALU_I: begin
                            regWrite   = 1'b1;
                            aluSrc     = 1'b1;
                            aluControl = decAlu;
                        end
                        CL_LUI: begin
                            regWrite = 1'b1;
                            wdSrc    = 2'b01;
                        end
                        CL_JAL: begin
                            regWrite = 1'b1;
                            wdSrc    = 2'b11;
                            pcSrc    = 2'b01;
                        end
                        CL_JALR: begin
                            regWrite = 1'b1;
                            wdSrc    = 2'b11;
                            pcSrc    = 2'b10;
                            aluSrc   = 1'b1;
                        end
                        CL_BRANCH: begin
                            aluControl = ALU_SUB;
                            pcSrc      = brTaken ? 2'b01 : 2'b00;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (decClass == CL_STORE);
                    aluSrc   = 1'b1;
                    if (dmem_ack) begin
                        pcWrite   = 1'b1;
                        retire    = 1'b1;
                        stateNext = S_FETCH;
                        if (decClass == CL_LOAD) begin
                            regWrite = 1'b1;
                            wdSrc    = 2'b10;
                        end
                    end else if (timeoutHit) begin
                        stateNext = S_TRAP;
                    end
                end
                S_TRAP: begin
                    invalid_instr = 1'b1;
                end
                default: stateNext = S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_control_mc.sv
// Testbench for sr_control_mc. Two instances share all inputs: dutA uses the
// default parameters, dutB uses MEM_TIMEOUT=4 and CNT_W=4 for the timeout and
// counter-wrap cases. Inputs are driven and outputs sampled at the falling edge.

module tb_sr_control_mc;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                           A_SLTU = 4'd4, A_SRL = 4'd6, A_SRA = 4'd7,
                           A_OR = 4'd8, A_AND = 4'd9;

    logic clk, rst, imemAck, dmemAck, aluZero, aluLt, aluLtu;
    logic [6:0] cmdOp, cmdF7;
    logic [2:0] cmdF3;

    logic aImemReq, aIrWrite, aDmemReq, aDmemWe, aPcWrite, aRegWrite, aAluSrc, aInvalid;
    logic [1:0] aPcSrc, aWdSrc;
    logic [3:0] aAluControl;
    logic [31:0] aRetired;

    logic bImemReq, bIrWrite, bDmemReq, bDmemWe, bPcWrite, bRegWrite, bAluSrc, bInvalid;
    logic [1:0] bPcSrc, bWdSrc;
    logic [3:0] bAluControl;
    logic [3:0] bRetired;

    logic [15:0] aAll, bAll;
    logic [10:0] aExec;
    assign aAll = {aImemReq, aIrWrite, aDmemReq, aDmemWe, aPcWrite, aPcSrc, aRegWrite,
                   aAluSrc, aWdSrc, aAluControl, aInvalid};
    assign bAll = {bImemReq, bIrWrite, bDmemReq, bDmemWe, bPcWrite, bPcSrc, bRegWrite,
                   bAluSrc, bWdSrc, bAluControl, bInvalid};
    assign aExec = {aRegWrite, aAluSrc, aWdSrc, aPcSrc, aPcWrite, aAluControl};

    sr_control_mc dutA (
        .clk(clk), .rst(rst), .imem_ack(imemAck), .dmem_ack(dmemAck),
        .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .aluLt(aluLt), .aluLtu(aluLtu),
        .imem_req(aImemReq), .irWrite(aIrWrite), .dmem_req(aDmemReq), .dmem_we(aDmemWe),
        .pcWrite(aPcWrite), .pcSrc(aPcSrc), .regWrite(aRegWrite), .aluSrc(aAluSrc),
        .wdSrc(aWdSrc), .aluControl(aAluControl), .invalid_instr(aInvalid),
        .retired(aRetired)
    );

    sr_control_mc #(.ALU_W(4), .MEM_TIMEOUT(4), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst), .imem_ack(imemAck), .dmem_ack(dmemAck),
        .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .aluLt(aluLt), .aluLtu(aluLtu),
        .imem_req(bImemReq), .irWrite(bIrWrite), .dmem_req(bDmemReq), .dmem_we(bDmemWe),
        .pcWrite(bPcWrite), .pcSrc(bPcSrc), .regWrite(bRegWrite), .aluSrc(bAluSrc),
        .wdSrc(bWdSrc), .aluControl(bAluControl), .invalid_instr(bInvalid),
        .retired(bRetired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] flags;   // {aluZero, aluLt, aluLtu}
        logic       valid;
        logic [10:0] exp;    // {regWrite, aluSrc, wdSrc, pcSrc, pcWrite, aluControl}
    } vec_t;

    function automatic vec_t mkV(input string n, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [2:0] flags,
                                 input logic valid, input logic [10:0] e);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.flags = flags;
        v.valid = valid; v.exp = e;
        return v;
    endfunction

    function automatic logic [10:0] mkE(input logic rw, input logic as, input logic [1:0] wd,
                                        input logic [1:0] pc, input logic [3:0] alu);
        return {rw, as, wd, pc, 1'b1, alu};
    endfunction

    vec_t vecs[$];

    // Leaves the bench in the first FETCH cycle after reset, at the falling edge
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; imemAck = 1'b0; dmemAck = 1'b0;
        @(negedge clk); #1;
        chk("reset_outs_a", 32'(aAll), 32'd0);
        chk("reset_retired_a", aRetired, 32'd0);
        chk("reset_outs_b", 32'(bAll), 32'd0);
        chk("reset_retired_b", 32'(bRetired), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_fetch", 32'({aImemReq, bImemReq, aInvalid, bInvalid}), 32'b1100);
    endtask

    task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        cmdOp = op; cmdF3 = f3; cmdF7 = f7;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int reqCycles;
        rst = 1'b1; imemAck = 1'b0; dmemAck = 1'b0;
        aluZero = 1'b0; aluLt = 1'b0; aluLtu = 1'b0;
        cmdOp = 7'd0; cmdF3 = 3'd0; cmdF7 = 7'd0;

        vecs.push_back(mkV("add",   7'b0110011, 3'b000, 7'b0000000, 3'b000, 1, mkE(1,0,2'b00,2'b00,A_ADD)));
        vecs.push_back(mkV("sub",   7'b0110011, 3'b000, 7'b0100000, 3'b000, 1, mkE(1,0,2'b00,2'b00,A_SUB)));
        vecs.push_back(mkV("sra",   7'b0110011, 3'b101, 7'b0100000, 3'b000, 1, mkE(1,0,2'b00,2'b00,A_SRA)));
        vecs.push_back(mkV("sltu",  7'b0110011, 3'b011, 7'b0000000, 3'b000, 1, mkE(1,0,2'b00,2'b00,A_SLTU)));
        vecs.push_back(mkV("and",   7'b0110011, 3'b111, 7'b0000000, 3'b000, 1, mkE(1,0,2'b00,2'b00,A_AND)));
        vecs.push_back(mkV("addi",  7'b0010011, 3'b000, 7'b0101010, 3'b000, 1, mkE(1,1,2'b00,2'b00,A_ADD)));
        vecs.push_back(mkV("slti",  7'b0010011, 3'b010, 7'b1111111, 3'b000, 1, mkE(1,1,2'b00,2'b00,A_SLT)));
        vecs.push_back(mkV("srai",  7'b0010011, 3'b101, 7'b0100000, 3'b000, 1, mkE(1,1,2'b00,2'b00,A_SRA)));
        vecs.push_back(mkV("srli",  7'b0010011, 3'b101, 7'b0000000, 3'b000, 1, mkE(1,1,2'b00,2'b00,A_SRL)));
        vecs.push_back(mkV("slli",  7'b0010011, 3'b001, 7'b0000000, 3'b000, 1, mkE(1,1,2'b00,2'b00,A_SLL)));
        vecs.push_back(mkV("ori",   7'b0010011, 3'b110, 7'b0000011, 3'b000, 1, mkE(1,1,2'b00,2'b00,A_OR)));
        vecs.push_back(mkV("lui",   7'b0110111, 3'b101, 7'b1010101, 3'b000, 1, mkE(1,0,2'b01,2'b00,A_ADD)));
        vecs.push_back(mkV("jal",   7'b1101111, 3'b011, 7'b0000000, 3'b000, 1, mkE(1,0,2'b11,2'b01,A_ADD)));
        vecs.push_back(mkV("jalr",  7'b1100111, 3'b000, 7'b0000000, 3'b000, 1, mkE(1,1,2'b11,2'b10,A_ADD)));
        vecs.push_back(mkV("beq_t", 7'b1100011, 3'b000, 7'b0000000, 3'b100, 1, mkE(0,0,2'b00,2'b01,A_SUB)));
        vecs.push_back(mkV("beq_n", 7'b1100011, 3'b000, 7'b0000000, 3'b011, 1, mkE(0,0,2'b00,2'b00,A_SUB)));
        vecs.push_back(mkV("bne_t", 7'b1100011, 3'b001, 7'b0000000, 3'b000, 1, mkE(0,0,2'b00,2'b01,A_SUB)));
        vecs.push_back(mkV("blt_t", 7'b1100011, 3'b100, 7'b0000000, 3'b010, 1, mkE(0,0,2'b00,2'b01,A_SUB)));
        vecs.push_back(mkV("bge_n", 7'b1100011, 3'b101, 7'b0000000, 3'b010, 1, mkE(0,0,2'b00,2'b00,A_SUB)));
        vecs.push_back(mkV("bltu_t",7'b1100011, 3'b110, 7'b0000000, 3'b001, 1, mkE(0,0,2'b00,2'b01,A_SUB)));
        vecs.push_back(mkV("bgeu_t",7'b1100011, 3'b111, 7'b0000000, 3'b000, 1, mkE(0,0,2'b00,2'b01,A_SUB)));
        vecs.push_back(mkV("bgeu_n",7'b1100011, 3'b111, 7'b0000000, 3'b001, 1, mkE(0,0,2'b00,2'b00,A_SUB)));
        vecs.push_back(mkV("bad_slli", 7'b0010011, 3'b001, 7'b0100000, 3'b000, 0, 11'd0));
        vecs.push_back(mkV("bad_rf7",  7'b0110011, 3'b000, 7'b0000001, 3'b000, 0, 11'd0));
        vecs.push_back(mkV("bad_jalr", 7'b1100111, 3'b001, 7'b0000000, 3'b000, 0, 11'd0));
        vecs.push_back(mkV("bad_br2",  7'b1100011, 3'b010, 7'b0000000, 3'b000, 0, 11'd0));
        vecs.push_back(mkV("bad_br3",  7'b1100011, 3'b011, 7'b0000000, 3'b000, 0, 11'd0));
        vecs.push_back(mkV("bad_op",   7'b1111111, 3'b000, 7'b0000000, 3'b000, 0, 11'd0));
        vecs.push_back(mkV("bad_lw",   7'b0000011, 3'b000, 7'b0000000, 3'b000, 0, 11'd0));
        vecs.push_back(mkV("bad_sw",   7'b0100011, 3'b001, 7'b0000000, 3'b000, 0, 11'd0));
        vecs.push_back(mkV("bad_auipc",7'b0010111, 3'b000, 7'b0000000, 3'b000, 0, 11'd0));

        // Table: FETCH (ack at once), DECODE, EXEC or TRAP, then the following cycle.
        // dmem_ack is held high throughout and must be ignored.
        foreach (vecs[i]) begin
            doReset();
            setInstr(vecs[i].op, vecs[i].f3, vecs[i].f7);
            {aluZero, aluLt, aluLtu} = vecs[i].flags;
            imemAck = 1'b1; dmemAck = 1'b1;
            #1;
            chk({vecs[i].name, "_fetch"},
                32'({aImemReq, aIrWrite, aDmemReq, aRegWrite, aPcWrite}), 32'b11000);
            @(negedge clk);
            imemAck = 1'b0;
            #1;
            chk({vecs[i].name, "_decode"},
                32'({aImemReq, aIrWrite, aDmemReq, aRegWrite, aPcWrite, aInvalid}), 32'd0);
            @(negedge clk); #1;
            if (vecs[i].valid) begin
                chk({vecs[i].name, "_exec"},
                    32'({aExec, aInvalid, aImemReq, aDmemReq}), 32'({vecs[i].exp, 3'b000}));
            end else begin
                chk({vecs[i].name, "_trap"},
                    32'({aInvalid, aRegWrite, aPcWrite, aImemReq, aDmemReq}), 32'b10000);
            end
            @(negedge clk); #1;
            if (vecs[i].valid) begin
                chk({vecs[i].name, "_next_fetch"}, 32'({aImemReq, aInvalid}), 32'b10);
                chk({vecs[i].name, "_retired"}, aRetired, 32'd1);
            end else begin
                chk({vecs[i].name, "_trap_hold"},
                    32'({aInvalid, aRegWrite, aPcWrite, aImemReq}), 32'b1000);
                chk({vecs[i].name, "_trap_retired"}, aRetired, 32'd0);
            end
            dmemAck = 1'b0;
        end

        // LW with dmem_ack after 5 wait cycles on dutA: 8 cycles in total
        doReset();
        setInstr(7'b0000011, 3'b010, 7'b0000000);
        imemAck = 1'b1;
        @(negedge clk);
        imemAck = 1'b0;
        @(negedge clk);
        reqCycles = 0;
        for (int k = 0; k < 6; k++) begin
            dmemAck = (k == 5);
            #1;
            if (aDmemReq) reqCycles++;
            chk("lw_mem_cycle",
                32'({aDmemReq, aDmemWe, aAluSrc, aAluControl, aRegWrite, aPcWrite, aWdSrc, aImemReq, aInvalid}),
                32'({1'b1, 1'b0, 1'b1, A_ADD, (k == 5), (k == 5), ((k == 5) ? 2'b10 : 2'b00), 1'b0, 1'b0}));
            @(negedge clk);
        end
        dmemAck = 1'b0;
        #1;
        chk("lw_req_cycles", 32'(reqCycles), 32'd6);
        chk("lw_back_to_fetch", 32'({aImemReq, aDmemReq}), 32'b10);
        chk("lw_retired", aRetired, 32'd1);

        // SW on dutB, no ack: 4 MEM cycles, then TRAP held for 100 cycles
        doReset();
        setInstr(7'b0100011, 3'b010, 7'b0000000);
        imemAck = 1'b1;
        @(negedge clk);
        imemAck = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sw_to_mem", 32'({bDmemReq, bDmemWe, bInvalid, bPcWrite}), 32'b1100);
            @(negedge clk);
        end
        for (int k = 0; k < 100; k++) begin
            imemAck = k[0]; dmemAck = k[1];
            #1;
            chk("sw_to_trap",
                32'({bInvalid, bImemReq, bDmemReq, bPcWrite, bRegWrite, bIrWrite, bRetired}),
                32'({1'b1, 5'b00000, 4'd0}));
            @(negedge clk);
        end
        doReset();

        // SW on dutB with ack in the 4th MEM cycle: the ack wins over the timeout
        setInstr(7'b0100011, 3'b010, 7'b0000000);
        imemAck = 1'b1;
        @(negedge clk);
        imemAck = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dmemAck = (k == 3);
            #1;
            chk("sw_ack_edge_mem", 32'({bDmemReq, bDmemWe, bPcWrite, bRegWrite}),
                32'({1'b1, 1'b1, (k == 3), 1'b0}));
            @(negedge clk);
        end
        dmemAck = 1'b0;
        #1;
        chk("sw_ack_edge_done", 32'({bImemReq, bInvalid, bRetired}), 32'({1'b1, 1'b0, 4'd1}));

        // FETCH timeout on dutB: 4 request cycles without imem_ack, then TRAP
        doReset();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fetch_wait", 32'({bImemReq, bIrWrite, bInvalid}), 32'b100);
            @(negedge clk);
        end
        #1;
        chk("fetch_timeout_trap", 32'({bInvalid, bImemReq}), 32'b10);

        // 16 back-to-back ADDIs: dutB's 4-bit counter wraps to 0
        doReset();
        setInstr(7'b0010011, 3'b000, 7'b0000000);
        for (int i = 0; i < 16; i++) begin
            imemAck = 1'b1;
            @(negedge clk);
            imemAck = 1'b0;
            @(negedge clk);
            @(negedge clk); #1;
            chk("wrap_retired_b", 32'(bRetired), 32'((i + 1) % 16));
            chk("wrap_retired_a", aRetired, 32'(i + 1));
        end

        // rst during a FETCH wait drops the request and silences every output
        @(negedge clk); #1;
        chk("fetch_wait_before_rst", 32'({aImemReq, bImemReq}), 32'b11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_mid_fetch_a", 32'(aAll), 32'd0);
        chk("rst_mid_fetch_b", 32'(bAll), 32'd0);
        chk("rst_mid_fetch_ret", 32'({aRetired[3:0], bRetired}), 32'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
